// File: rtl/dice_race_pkg.sv
// Shared types and widths for the dice race game.
// Contents:
//   color_t      - filtered colour code from the detector (NONE/RED/GREEN/BLUE)
//   turn_state_t - turn sequencer FSM states, encodings visible on turn_state
//   PLAYER_W     - width of a player ID
//   POS_W        - width of one board position
package dice_race_pkg;

    localparam int PLAYER_W = 2;
    localparam int POS_W    = 5;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        RED   = 2'd1,
        GREEN = 2'd2,
        BLUE  = 2'd3
    } color_t;

    typedef enum logic [2:0] {
        WAIT_ROLL = 3'd0,
        DETECT    = 3'd1,
        MOVE      = 3'd2,
        CHECK     = 3'd3,
        NEXT      = 3'd4,
        GAME_OVER = 3'd5
    } turn_state_t;

endpackage

// File: rtl/dice_confirm_counter.sv
// Roll confirmation counters: tracks the candidate step value, how many
// consecutive frames agreed on it, and how many frames have been seen.
// Ports:
//   clk, reset_n       - clock, asynchronous active-low reset
//   clear              - synchronous clear of all counters (dominates)
//   result_ready       - one pulse per detector frame
//   steps              - steps reported for this frame (0 = nothing seen)
//   confirmed          - this frame completes CONFIRM_COUNT matching results
//   confirmed_steps    - the step value being confirmed
//   timed_out          - this frame exhausts TIMEOUT_FRAMES without a confirm
module dice_confirm_counter
    import dice_race_pkg::*;
#(
    parameter int CONFIRM_COUNT  = 3,
    parameter int TIMEOUT_FRAMES = 90
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       result_ready,
    input  logic [1:0] steps,
    output logic       confirmed,
    output logic [1:0] confirmed_steps,
    output logic       timed_out
);

    logic [1:0] cand_q, cand_d;
    logic [2:0] match_q, match_d;
    logic [7:0] frame_q, frame_d;

    // Next counter values for the current frame. The verdicts are taken from
    // the updated counts so the FSM can react on the same result_ready edge.
    // A confirm on the last allowed frame wins over the timeout.
    always_comb begin
        cand_d  = cand_q;
        match_d = match_q;
        frame_d = frame_q;
        if (result_ready) begin
            frame_d = frame_q + 8'd1;
            if (steps == 2'd0) begin
                match_d = 3'd0;
            end else if (steps == cand_q && match_q != 3'd0) begin
                match_d = match_q + 3'd1;
            end else begin
                cand_d  = steps;
                match_d = 3'd1;
            end
        end
        confirmed       = result_ready && (match_d == 3'(CONFIRM_COUNT));
        timed_out       = result_ready && !confirmed && (frame_d == 8'(TIMEOUT_FRAMES));
        confirmed_steps = cand_d;
    end

    // Counter registers. The owner holds clear high outside the detection
    // window, so every detection attempt starts from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_q  <= 2'd0;
            match_q <= 3'd0;
            frame_q <= 8'd0;
        end else if (clear) begin
            cand_q  <= 2'd0;
            match_q <= 3'd0;
            frame_q <= 8'd0;
        end else begin
            cand_q  <= cand_d;
            match_q <= match_d;
            frame_q <= frame_d;
        end
    end

endmodule

// File: rtl/dice_turn_controller.sv
// Turn sequencer for the dice race game: arms detection on roll, confirms a
// dice result, hands the move to the board FSM via valid/ready, tracks
// positions, declares the winner and rotates turns.
// Ports:
//   clk, reset_n                  - clock, asynchronous active-low reset
//   new_game                      - synchronous clear of the whole game
//   roll_btn                      - single-cycle roll request
//   result_ready/stable_color/
//   movement_steps                - filtered detector result, one per frame
//   detect_enable                 - high while detecting
//   move_valid/move_player/
//   move_steps/move_ready         - move handshake to the board FSM
//   current_player                - whose turn it is
//   position                      - packed positions, player 0 in the LSBs
//   timeout_pulse                 - one-cycle pulse when a roll is abandoned
//   winner_valid/winner_id        - game result, held until new_game
//   turn_state                    - debug view of the FSM state
module dice_turn_controller
    import dice_race_pkg::*;
#(
    parameter int NUM_PLAYERS    = 2,
    parameter int CONFIRM_COUNT  = 3,
    parameter int TIMEOUT_FRAMES = 90,
    parameter int BOARD_LEN      = 20
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         new_game,
    input  logic                         roll_btn,
    input  logic                         result_ready,
    input  logic [1:0]                   stable_color,
    input  logic [1:0]                   movement_steps,
    output logic                         detect_enable,
    output logic                         move_valid,
    output logic [PLAYER_W-1:0]          move_player,
    output logic [1:0]                   move_steps,
    input  logic                         move_ready,
    output logic [PLAYER_W-1:0]          current_player,
    output logic [POS_W*NUM_PLAYERS-1:0] position,
    output logic                         timeout_pulse,
    output logic                         winner_valid,
    output logic [PLAYER_W-1:0]          winner_id,
    output logic [2:0]                   turn_state
);

    turn_state_t       state_q;
    logic [POS_W-1:0]  pos_q [NUM_PLAYERS];

    logic              cnt_clear;
    logic [1:0]        steps_eff;
    logic              confirmed;
    logic [1:0]        confirmed_steps;
    logic              timed_out;

    logic [POS_W-1:0]  sel_pos;
    logic [POS_W:0]    pos_sum;
    logic [POS_W-1:0]  sat_pos;
    logic [PLAYER_W-1:0] next_player;

    // Counters only run while detecting; clearing them at all other times
    // also guarantees a fresh start on every entry to DETECT, and a frame
    // arriving on the roll edge itself is dropped.
    assign cnt_clear = new_game || (state_q != DETECT);

    // A NONE colour never counts as a move even if the step mapping glitches.
    assign steps_eff = (color_t'(stable_color) == NONE) ? 2'd0 : movement_steps;

    dice_confirm_counter #(
        .CONFIRM_COUNT  (CONFIRM_COUNT),
        .TIMEOUT_FRAMES (TIMEOUT_FRAMES)
    ) u_confirm (
        .clk             (clk),
        .reset_n         (reset_n),
        .clear           (cnt_clear),
        .result_ready    (result_ready),
        .steps           (steps_eff),
        .confirmed       (confirmed),
        .confirmed_steps (confirmed_steps),
        .timed_out       (timed_out)
    );

    // Position of the moving player, its saturated new value, and the next
    // player in rotation. The sum uses one extra bit so it cannot wrap before
    // saturation.
    always_comb begin
        sel_pos = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (PLAYER_W'(i) == move_player) begin
                sel_pos = pos_q[i];
            end
        end
        pos_sum     = {1'b0, sel_pos} + {{(POS_W-1){1'b0}}, move_steps};
        sat_pos     = (pos_sum > (POS_W+1)'(BOARD_LEN)) ? POS_W'(BOARD_LEN) : pos_sum[POS_W-1:0];
        next_player = (current_player == PLAYER_W'(NUM_PLAYERS-1)) ? '0 : current_player + 1'b1;
    end

    // Turn FSM with registered outputs. new_game dominates every state and
    // also drops a pending move offer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= WAIT_ROLL;
            detect_enable  <= 1'b0;
            move_valid     <= 1'b0;
            move_player    <= '0;
            move_steps     <= 2'd0;
            current_player <= '0;
            timeout_pulse  <= 1'b0;
            winner_valid   <= 1'b0;
            winner_id      <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) pos_q[i] <= '0;
        end else if (new_game) begin
            state_q        <= WAIT_ROLL;
            detect_enable  <= 1'b0;
            move_valid     <= 1'b0;
            move_player    <= '0;
            move_steps     <= 2'd0;
            current_player <= '0;
            timeout_pulse  <= 1'b0;
            winner_valid   <= 1'b0;
            winner_id      <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) pos_q[i] <= '0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state_q)
                WAIT_ROLL: begin
                    if (roll_btn) begin
                        state_q       <= DETECT;
                        detect_enable <= 1'b1;
                    end
                end
                DETECT: begin
                    if (confirmed) begin
                        state_q       <= MOVE;
                        detect_enable <= 1'b0;
                        move_valid    <= 1'b1;
                        move_steps    <= confirmed_steps;
                        move_player   <= current_player;
                    end else if (timed_out) begin
                        state_q       <= WAIT_ROLL;
                        detect_enable <= 1'b0;
                        timeout_pulse <= 1'b1;
                    end
                end
                MOVE: begin
                    if (move_ready) begin
                        for (int i = 0; i < NUM_PLAYERS; i++) begin
                            if (PLAYER_W'(i) == move_player) pos_q[i] <= sat_pos;
                        end
                        move_valid <= 1'b0;
                        state_q    <= CHECK;
                    end
                end
                CHECK: begin
                    if (sel_pos == POS_W'(BOARD_LEN)) begin
                        state_q      <= GAME_OVER;
                        winner_valid <= 1'b1;
                        winner_id    <= move_player;
                    end else begin
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    current_player <= next_player;
                    state_q        <= WAIT_ROLL;
                end
                GAME_OVER: begin
                    state_q <= GAME_OVER;
                end
                default: begin
                    state_q <= WAIT_ROLL;
                end
            endcase
        end
    end

    assign turn_state = state_q;

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pos
        assign position[g*POS_W +: POS_W] = pos_q[g];
    end

endmodule

// File: tb/tb_dice_turn_controller.sv
// Self-checking bench for dice_turn_controller. Each turn is described as a
// list of per-frame step values; a turn-level model decides from that list
// whether and when the roll is confirmed or abandoned, and tracks positions,
// turn order and the winner.
module tb_dice_turn_controller;

    localparam int NP    = 2;
    localparam int CC    = 3;
    localparam int TO    = 6;
    localparam int BL    = 20;
    localparam int POS_W = 5;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            new_game;
    logic            roll_btn;
    logic            result_ready;
    logic [1:0]      stable_color;
    logic [1:0]      movement_steps;
    logic            detect_enable;
    logic            move_valid;
    logic [1:0]      move_player;
    logic [1:0]      move_steps;
    logic            move_ready;
    logic [1:0]      current_player;
    logic [POS_W*NP-1:0] position;
    logic            timeout_pulse;
    logic            winner_valid;
    logic [1:0]      winner_id;
    logic [2:0]      turn_state;

    int total = 0;
    int bad   = 0;

    int mdl_pos [NP];
    int mdl_cp;
    bit mdl_over;
    int frames [$];

    dice_turn_controller #(
        .NUM_PLAYERS    (NP),
        .CONFIRM_COUNT  (CC),
        .TIMEOUT_FRAMES (TO),
        .BOARD_LEN      (BL)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .new_game       (new_game),
        .roll_btn       (roll_btn),
        .result_ready   (result_ready),
        .stable_color   (stable_color),
        .movement_steps (movement_steps),
        .detect_enable  (detect_enable),
        .move_valid     (move_valid),
        .move_player    (move_player),
        .move_steps     (move_steps),
        .move_ready     (move_ready),
        .current_player (current_player),
        .position       (position),
        .timeout_pulse  (timeout_pulse),
        .winner_valid   (winner_valid),
        .winner_id      (winner_id),
        .turn_state     (turn_state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic modelClear();
        for (int i = 0; i < NP; i++) mdl_pos[i] = 0;
        mdl_cp   = 0;
        mdl_over = 0;
    endtask

    task automatic checkPositions(input string tag);
        for (int i = 0; i < NP; i++)
            checkOutput($sformatf("%s pos%0d", tag, i), int'(position[i*POS_W +: POS_W]), mdl_pos[i]);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " state"}, int'(turn_state), 0);
        checkOutput({tag, " detect_enable"}, int'(detect_enable), 0);
        checkOutput({tag, " move_valid"}, int'(move_valid), 0);
        checkOutput({tag, " winner_valid"}, int'(winner_valid), 0);
        checkOutput({tag, " current_player"}, int'(current_player), mdl_cp);
        checkPositions(tag);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " detect_enable"}, int'(detect_enable), 0);
        checkOutput({tag, " move_valid"}, int'(move_valid), 0);
        checkOutput({tag, " move_player"}, int'(move_player), 0);
        checkOutput({tag, " move_steps"}, int'(move_steps), 0);
        checkOutput({tag, " current_player"}, int'(current_player), 0);
        checkOutput({tag, " position"}, int'(position), 0);
        checkOutput({tag, " timeout_pulse"}, int'(timeout_pulse), 0);
        checkOutput({tag, " winner_valid"}, int'(winner_valid), 0);
        checkOutput({tag, " winner_id"}, int'(winner_id), 0);
        checkOutput({tag, " state"}, int'(turn_state), 0);
    endtask

    task automatic padFrames();
        while (frames.size() < TO) frames.push_back(0);
    endtask

    task automatic randomFrames();
        int prev;
        frames.delete();
        prev = $urandom_range(0, 3);
        for (int k = 0; k < TO; k++) begin
            if ($urandom_range(0, 99) >= 70) prev = $urandom_range(0, 3);
            frames.push_back(prev);
        end
    endtask

    // Turn outcome straight from the game rules: the roll is accepted on the
    // first frame that ends a run of CC identical non-zero results, otherwise
    // abandoned on frame TO. kind 0 = confirmed, 1 = timed out.
    task automatic modelOutcome(output int idx, output int kind);
        int run;
        idx  = TO - 1;
        kind = 1;
        for (int i = 0; i < frames.size(); i++) begin
            run = 0;
            if (frames[i] != 0) begin
                for (int j = i; j >= 0 && frames[j] == frames[i]; j--) run++;
            end
            if (run >= CC) begin
                idx = i; kind = 0; return;
            end
            if (i + 1 == TO) begin
                idx = i; kind = 1; return;
            end
        end
    endtask

    task automatic pulseFrame(input int v);
        result_ready   = 1'b1;
        movement_steps = 2'(v);
        stable_color   = 2'(v);
        tick();
        result_ready   = 1'b0;
        movement_steps = 2'd0;
        stable_color   = 2'd0;
    endtask

    // One full turn for the active player using the current frame list.
    task automatic applyStimulus(input int ready_delay, input bit early_rr);
        int idx, kind, p, st, ev;
        p = mdl_cp;
        modelOutcome(idx, kind);
        roll_btn = 1'b1;
        if (early_rr) begin
            ev = (frames[0] != 0) ? frames[0] : 1;
            result_ready   = 1'b1;
            movement_steps = 2'(ev);
            stable_color   = 2'(ev);
        end
        tick();
        roll_btn = 1'b0; result_ready = 1'b0; movement_steps = 2'd0; stable_color = 2'd0;
        checkOutput("roll detect_enable", int'(detect_enable), 1);
        checkOutput("roll state", int'(turn_state), 1);
        for (int i = 0; i <= idx; i++) begin
            repeat ($urandom_range(0, 2)) begin
                roll_btn   = 1'($urandom_range(0, 1));
                move_ready = 1'($urandom_range(0, 1));
                tick();
                roll_btn = 1'b0; move_ready = 1'b0;
                checkOutput("gap detect_enable", int'(detect_enable), 1);
            end
            pulseFrame(frames[i]);
            if (i < idx) begin
                checkOutput("frame detect_enable", int'(detect_enable), 1);
                checkOutput("frame move_valid", int'(move_valid), 0);
                checkOutput("frame timeout_pulse", int'(timeout_pulse), 0);
            end
        end
        if (kind == 0) begin
            st = frames[idx];
            checkOutput("confirm move_valid", int'(move_valid), 1);
            checkOutput("confirm move_steps", int'(move_steps), st);
            checkOutput("confirm move_player", int'(move_player), p);
            checkOutput("confirm detect_enable", int'(detect_enable), 0);
            for (int d = 0; d < ready_delay; d++) begin
                move_ready     = 1'b0;
                result_ready   = 1'($urandom_range(0, 1));
                movement_steps = 2'($urandom_range(1, 3));
                stable_color   = movement_steps;
                tick();
                result_ready = 1'b0; movement_steps = 2'd0; stable_color = 2'd0;
                checkOutput("hold move_valid", int'(move_valid), 1);
                checkOutput("hold move_steps", int'(move_steps), st);
                checkOutput("hold move_player", int'(move_player), p);
                checkOutput("hold state", int'(turn_state), 2);
                checkPositions("hold");
            end
            move_ready = 1'b1;
            tick();
            move_ready = 1'b0;
            mdl_pos[p] = (mdl_pos[p] + st > BL) ? BL : mdl_pos[p] + st;
            checkOutput("xfer move_valid", int'(move_valid), 0);
            checkOutput("xfer state", int'(turn_state), 3);
            checkPositions("xfer");
            tick();
            if (mdl_pos[p] == BL) begin
                mdl_over = 1;
                checkOutput("win state", int'(turn_state), 5);
                checkOutput("win winner_valid", int'(winner_valid), 1);
                checkOutput("win winner_id", int'(winner_id), p);
            end else begin
                checkOutput("next state", int'(turn_state), 4);
                checkOutput("next winner_valid", int'(winner_valid), 0);
                tick();
                mdl_cp = (p + 1) % NP;
                checkIdle("rotate");
            end
        end else begin
            checkOutput("timeout pulse", int'(timeout_pulse), 1);
            checkIdle("timeout");
            tick();
            checkOutput("timeout pulse drop", int'(timeout_pulse), 0);
        end
    endtask

    task automatic doNewGame(input string tag);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        modelClear();
        checkIdle(tag);
        checkOutput({tag, " winner_id"}, int'(winner_id), 0);
    endtask

    initial begin
        int turns;
        new_game = 0; roll_btn = 0; result_ready = 0;
        stable_color = 0; movement_steps = 0; move_ready = 0;
        modelClear();
        reset_n = 1'b0;
        #1;
        checkAllZero("reset");
        #20;
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Basic roll, ready already high when the offer appears
        frames = '{2, 2, 2}; padFrames();
        applyStimulus(0, 0);
        checkOutput("basic cp", int'(current_player), 1);

        // Mismatch restarts confirmation
        frames = '{1, 1, 3, 3, 3}; padFrames();
        applyStimulus(1, 0);

        // NONE mid-run, confirm lands on the last allowed frame
        frames = '{2, 2, 0, 2, 2, 2};
        applyStimulus(2, 0);

        // All-NONE roll times out, same player keeps the turn
        frames = '{0, 0, 0, 0, 0, 0};
        applyStimulus(0, 0);
        checkOutput("timeout same player", int'(current_player), 1);

        // Long backpressure, plus a result on the roll edge that must be dropped
        frames = '{1, 1, 1}; padFrames();
        applyStimulus(10, 1);

        // new_game during DETECT, then a fresh roll needs a full confirm run
        roll_btn = 1'b1; tick(); roll_btn = 1'b0;
        pulseFrame(3); pulseFrame(3);
        doNewGame("clear in detect");
        frames = '{3, 3, 3}; padFrames();
        applyStimulus(0, 0);

        // Asynchronous reset while a move is offered
        roll_btn = 1'b1; tick(); roll_btn = 1'b0;
        pulseFrame(1); pulseFrame(1); pulseFrame(1);
        checkOutput("pre-reset move_valid", int'(move_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkAllZero("async reset");
        modelClear();
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Bring player 1 to 19 then win with 3 (saturates at 20)
        for (int k = 0; k < 7; k++) begin
            frames = '{1, 1, 1}; padFrames();
            applyStimulus($urandom_range(0, 3), 0);
            if (k < 6) frames = '{3, 3, 3}; else frames = '{1, 1, 1};
            padFrames();
            applyStimulus($urandom_range(0, 3), 0);
        end
        checkOutput("pre-win pos1", int'(position[POS_W +: POS_W]), 19);
        frames = '{1, 1, 1}; padFrames();
        applyStimulus(0, 0);
        frames = '{3, 3, 3}; padFrames();
        applyStimulus(1, 0);
        checkOutput("saturated pos1", int'(position[POS_W +: POS_W]), BL);
        roll_btn = 1'b1; tick(); roll_btn = 1'b0; tick();
        checkOutput("game over roll ignored", int'(turn_state), 5);
        checkOutput("game over winner held", int'(winner_valid), 1);
        doNewGame("new game after win");

        // Random games
        for (int g = 0; g < 3; g++) begin
            turns = 0;
            while (!mdl_over && turns < 200) begin
                randomFrames();
                applyStimulus($urandom_range(0, 4), 1'($urandom_range(0, 1)));
                turns++;
            end
            if (mdl_over) begin
                roll_btn = 1'b1; tick(); roll_btn = 1'b0;
                checkOutput("random game over hold", int'(turn_state), 5);
            end
            doNewGame("random new game");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
